// File: rtl/memory_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the RAM.
// The slave view belongs to the arbiter; the master view belongs to the surrounding system.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data requests normally win, but an instruction fetch is
// forced through after STARVE_LIMIT consecutive data grants while it waits.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);

  state_t     state;
  state_t     next_state;
  logic [2:0] starve_cnt;
  logic       d_req;
  logic       ram_acc;
  logic       ram_err;
  logic       i_done;
  logic       d_done;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= LIMIT) ? LIMIT : v + 3'd1;
  endfunction

  assign d_req   = bus.dREN | bus.dWEN;
  assign ram_acc = (bus.ramstate == RAM_ACCESS);
  assign ram_err = (bus.ramstate == RAM_ERROR);
  assign i_done  = (state == IBUSY) & ram_acc & bus.iREN;
  assign d_done  = (state == DBUSY) & ram_acc & d_req;

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  assign bus.iwait = bus.iREN & ~((state == IBUSY) & ram_acc);
  assign bus.dwait = d_req & ~((state == DBUSY) & ram_acc);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Starvation counter: only meaningful while an instruction fetch is waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= 3'd0;
    end else if (!bus.iREN || i_done) begin
      starve_cnt <= 3'd0;
    end else if (d_done) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  always_comb begin
    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    case (state)
      IDLE: begin
        if (d_req && !(bus.iREN && starve_cnt == LIMIT)) begin
          next_state = DBUSY;
        end else if (bus.iREN) begin
          next_state = IBUSY;
        end
      end
      IBUSY: begin
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          if (ram_acc || ram_err) next_state = IDLE;
        end
      end
      DBUSY: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          // A simultaneous read and write is treated as a write.
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN & ~bus.dWEN;
          if (ram_acc || ram_err) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a per-cycle vector table plus a reset-mid-transfer sequence.
module tb_memory_arbiter;

  localparam logic [1:0] RS_F = 2'd0, RS_B = 2'd1, RS_A = 2'd2, RS_E = 2'd3;
  localparam logic [1:0] S_ID = 2'd0, S_IB = 2'd1, S_DB = 2'd2;

  typedef struct {
    logic        i_ren;
    logic        d_ren;
    logic        d_wen;
    logic [1:0]  rs;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  e_st;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_iw;
    logic        e_dw;
    logic [2:0]  e_cnt;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic ir, input logic dr, input logic dw, input logic [1:0] rs,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                     input logic [1:0] st, input logic ren, input logic wen,
                     input logic [31:0] ad, input logic [31:0] sto,
                     input logic iw, input logic dwt, input logic [2:0] cnt);
    vec_t v;
    v.i_ren = ir;  v.d_ren = dr;  v.d_wen = dw;  v.rs = rs;
    v.iaddr = ia;  v.daddr = da;  v.dstore = ds;
    v.e_st = st;   v.e_ren = ren; v.e_wen = wen; v.e_addr = ad; v.e_store = sto;
    v.e_iw = iw;   v.e_dw = dwt;  v.e_cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw, input logic [1:0] rs,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                       input logic [31:0] rl);
    bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw; bus.ramstate = rs;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds; bus.ramload = rl;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] rl;

    // Reset held: outputs idle, waits follow the requests with state IDLE.
    drive(1'b1, 1'b0, 1'b0, RS_A, 32'h40, 32'h0, 32'h0, 32'h1234_5678);
    #2;
    check("rst_state", 0, 32'(dut.state), 32'(S_ID));
    check("rst_cnt", 0, 32'(dut.starve_cnt), 32'd0);
    check("rst_ramREN", 0, 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 0, 32'(bus.ramWEN), 32'd0);
    check("rst_ramaddr", 0, bus.ramaddr, 32'd0);
    check("rst_iwait", 0, 32'(bus.iwait), 32'd1);
    check("rst_dwait", 0, 32'(bus.dwait), 32'd0);
    check("rst_iload", 0, bus.iload, 32'h1234_5678);
    next_cycle();
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, RS_F, 32'h0, 32'h0, 32'h0, 32'h0);
    nRST = 1'b1;
    next_cycle();

    // Single instruction fetch, ACCESS in the first busy cycle.
    add(1,0,0,RS_F,32'h40,32'h0,32'h0,               S_ID,0,0,32'h0,32'h0,1,0,0);
    add(1,0,0,RS_A,32'h40,32'h0,32'h0,               S_IB,1,0,32'h40,32'h0,0,0,0);
    add(0,0,0,RS_F,32'h40,32'h0,32'h0,               S_ID,0,0,32'h0,32'h0,0,0,0);
    // Data write with RAM BUSY for three cycles.
    add(0,0,1,RS_F,32'h0,32'h100,32'hDEADBEEF,       S_ID,0,0,32'h0,32'h0,0,1,0);
    add(0,0,1,RS_B,32'h0,32'h100,32'hDEADBEEF,       S_DB,0,1,32'h100,32'hDEADBEEF,0,1,0);
    add(0,0,1,RS_B,32'h0,32'h100,32'hDEADBEEF,       S_DB,0,1,32'h100,32'hDEADBEEF,0,1,0);
    add(0,0,1,RS_B,32'h0,32'h100,32'hDEADBEEF,       S_DB,0,1,32'h100,32'hDEADBEEF,0,1,0);
    add(0,0,1,RS_A,32'h0,32'h100,32'hDEADBEEF,       S_DB,0,1,32'h100,32'hDEADBEEF,0,0,0);
    add(0,0,0,RS_F,32'h0,32'h100,32'hDEADBEEF,       S_ID,0,0,32'h0,32'h0,0,0,0);
    // Simultaneous instruction and data requests: data first.
    add(1,1,0,RS_A,32'h44,32'h200,32'h0,             S_ID,0,0,32'h0,32'h0,1,1,0);
    add(1,1,0,RS_A,32'h44,32'h200,32'h0,             S_DB,1,0,32'h200,32'h0,1,0,0);
    add(1,0,0,RS_A,32'h44,32'h200,32'h0,             S_ID,0,0,32'h0,32'h0,1,0,1);
    add(1,0,0,RS_A,32'h44,32'h200,32'h0,             S_IB,1,0,32'h44,32'h0,0,0,1);
    add(0,0,0,RS_A,32'h44,32'h200,32'h0,             S_ID,0,0,32'h0,32'h0,0,0,0);
    // Starvation: four data grants, one forced instruction grant, data resumes.
    for (int g = 0; g < 4; g++) begin
      add(1,1,0,RS_A,32'h48,32'h300,32'h0,           S_ID,0,0,32'h0,32'h0,1,1,3'(g));
      add(1,1,0,RS_A,32'h48,32'h300,32'h0,           S_DB,1,0,32'h300,32'h0,1,0,3'(g));
    end
    add(1,1,0,RS_A,32'h48,32'h300,32'h0,             S_ID,0,0,32'h0,32'h0,1,1,4);
    add(1,1,0,RS_A,32'h48,32'h300,32'h0,             S_IB,1,0,32'h48,32'h0,0,1,4);
    add(1,1,0,RS_A,32'h48,32'h300,32'h0,             S_ID,0,0,32'h0,32'h0,1,1,0);
    add(1,1,0,RS_A,32'h48,32'h300,32'h0,             S_DB,1,0,32'h300,32'h0,1,0,0);
    add(0,0,0,RS_A,32'h48,32'h300,32'h0,             S_ID,0,0,32'h0,32'h0,0,0,1);
    // ERROR on a data read: retry after one IDLE cycle.
    add(0,1,0,RS_F,32'h0,32'h400,32'h0,              S_ID,0,0,32'h0,32'h0,0,1,0);
    add(0,1,0,RS_E,32'h0,32'h400,32'h0,              S_DB,1,0,32'h400,32'h0,0,1,0);
    add(0,1,0,RS_F,32'h0,32'h400,32'h0,              S_ID,0,0,32'h0,32'h0,0,1,0);
    add(0,1,0,RS_A,32'h0,32'h400,32'h0,              S_DB,1,0,32'h400,32'h0,0,0,0);
    add(0,0,0,RS_F,32'h0,32'h400,32'h0,              S_ID,0,0,32'h0,32'h0,0,0,0);
    // Instruction request withdrawn while busy: enables drop, back to IDLE.
    add(1,0,0,RS_F,32'h50,32'h0,32'h0,               S_ID,0,0,32'h0,32'h0,1,0,0);
    add(1,0,0,RS_B,32'h50,32'h0,32'h0,               S_IB,1,0,32'h50,32'h0,1,0,0);
    add(0,0,0,RS_B,32'h50,32'h0,32'h0,               S_IB,0,0,32'h50,32'h0,0,0,0);
    add(0,0,0,RS_F,32'h50,32'h0,32'h0,               S_ID,0,0,32'h0,32'h0,0,0,0);
    // Read and write together: write wins.
    add(0,1,1,RS_A,32'h0,32'h600,32'hCAFEF00D,       S_ID,0,0,32'h0,32'h0,0,1,0);
    add(0,1,1,RS_A,32'h0,32'h600,32'hCAFEF00D,       S_DB,0,1,32'h600,32'hCAFEF00D,0,0,0);
    add(0,0,0,RS_F,32'h0,32'h600,32'hCAFEF00D,       S_ID,0,0,32'h0,32'h0,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      rl = 32'h8C010004 + 32'((i - 1) * 256);
      drive(vq[i].i_ren, vq[i].d_ren, vq[i].d_wen, vq[i].rs,
            vq[i].iaddr, vq[i].daddr, vq[i].dstore, rl);
      #1;
      check("state",    i + 1, 32'(dut.state),      32'(vq[i].e_st));
      check("ramREN",   i + 1, 32'(bus.ramREN),     32'(vq[i].e_ren));
      check("ramWEN",   i + 1, 32'(bus.ramWEN),     32'(vq[i].e_wen));
      check("ramaddr",  i + 1, bus.ramaddr,          vq[i].e_addr);
      check("ramstore", i + 1, bus.ramstore,         vq[i].e_store);
      check("iwait",    i + 1, 32'(bus.iwait),      32'(vq[i].e_iw));
      check("dwait",    i + 1, 32'(bus.dwait),      32'(vq[i].e_dw));
      check("iload",    i + 1, bus.iload,            rl);
      check("dload",    i + 1, bus.dload,            rl);
      check("starve",   i + 1, 32'(dut.starve_cnt), 32'(vq[i].e_cnt));
      next_cycle();
    end

    // Reset pulsed while a data write is stalled on a BUSY RAM.
    drive(1'b1, 1'b0, 1'b1, RS_A, 32'h70, 32'h500, 32'h1111_2222, 32'h0);
    #1;
    check("pre_state", 100, 32'(dut.state), 32'(S_ID));
    next_cycle();
    #1;
    check("pre_wen", 101, 32'(bus.ramWEN), 32'd1);
    next_cycle();
    next_cycle();
    bus.ramstate = RS_B;
    #1;
    check("pre_state", 102, 32'(dut.state), 32'(S_DB));
    check("pre_wen", 102, 32'(bus.ramWEN), 32'd1);
    check("pre_cnt", 102, 32'(dut.starve_cnt), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("rstmid_wen", 103, 32'(bus.ramWEN), 32'd0);
    check("rstmid_ren", 103, 32'(bus.ramREN), 32'd0);
    check("rstmid_state", 103, 32'(dut.state), 32'(S_ID));
    check("rstmid_cnt", 103, 32'(dut.starve_cnt), 32'd0);
    check("rstmid_dwait", 103, 32'(bus.dwait), 32'd1);
    check("rstmid_iwait", 103, 32'(bus.iwait), 32'd1);
    next_cycle();
    check("rsthold_state", 104, 32'(dut.state), 32'(S_ID));
    nRST = 1'b1;
    #1;
    check("post_state", 105, 32'(dut.state), 32'(S_ID));
    check("post_wen", 105, 32'(bus.ramWEN), 32'd0);
    next_cycle();
    check("post_grant", 106, 32'(dut.state), 32'(S_DB));
    check("post_wen", 106, 32'(bus.ramWEN), 32'd1);
    check("post_addr", 106, bus.ramaddr, 32'h500);
    drive(1'b0, 1'b0, 1'b0, RS_F, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
